// File: rtl/audio_stream_sequencer.sv
// Sequences codec read/write handshakes, steps and primes the stereo filter,
// and selects the output source, switching modes only between samples.
module audio_stream_sequencer #(
  parameter int DATA_WIDTH  = 24,
  parameter int PRIME_COUNT = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_ready,
  input  logic                         write_ready,
  input  logic signed [DATA_WIDTH-1:0] readdata_left,
  input  logic signed [DATA_WIDTH-1:0] readdata_right,
  output logic                         read,
  output logic                         write,
  output logic signed [DATA_WIDTH-1:0] writedata_left,
  output logic signed [DATA_WIDTH-1:0] writedata_right,
  output logic signed [DATA_WIDTH-1:0] sample_left,
  output logic signed [DATA_WIDTH-1:0] sample_right,
  input  logic signed [DATA_WIDTH-1:0] filt_left,
  input  logic signed [DATA_WIDTH-1:0] filt_right,
  output logic                         filt_step,
  output logic                         filt_clear,
  input  logic [1:0]                   mode_req,
  input  logic                         mode_req_valid,
  output logic [1:0]                   mode,
  output logic                         priming,
  output logic [CNT_WIDTH-1:0]         overrun_cnt
);

  typedef enum logic [1:0] {ST_CLEAR, ST_PRIME, ST_RUN} state_t;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_FILTER = 2'd1;
  localparam int         PW          = $clog2(PRIME_COUNT + 1);

  state_t          state, state_next;
  logic [PW-1:0]   prime_cnt, prime_cnt_next;
  logic [1:0]      mode_next, pend_mode, pend_mode_next;
  logic            pend, pend_next;
  logic [1:0]      gap;
  logic            step_d1, wb_d2, mute_d1, mute_d2;
  logic            active, transfer, apply;

  // Strobes are gated by reset so an in-flight sample cannot fire on the reset cycle.
  assign active     = (state == ST_PRIME) || (state == ST_RUN);
  assign transfer   = !reset && read_ready && write_ready && (gap == 2'd0) && active;
  assign apply      = !reset && pend && (gap == 2'd0) && !transfer && active;
  assign read       = transfer;
  assign write      = transfer;
  assign filt_step  = step_d1 && !reset;
  assign filt_clear = (state == ST_CLEAR) && !reset;
  assign priming    = (state == ST_PRIME);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    prime_cnt_next = prime_cnt;
    mode_next      = mode;
    pend_next      = pend;
    pend_mode_next = pend_mode;

    case (state)
      ST_CLEAR: begin
        prime_cnt_next = '0;
        state_next     = (mode == MODE_FILTER) ? ST_PRIME : ST_RUN;
      end
      ST_PRIME: begin
        if (transfer) begin
          if (prime_cnt == PW'(PRIME_COUNT - 1)) state_next = ST_RUN;
          else prime_cnt_next = prime_cnt + PW'(1);
        end
      end
      ST_RUN:  ;
      default: state_next = ST_CLEAR;
    endcase

    if (apply) begin
      mode_next  = pend_mode;
      state_next = ST_CLEAR;
      pend_next  = 1'b0;
    end

    // A new request is judged against the mode that will be active after this edge.
    if (mode_req_valid) begin
      pend_mode_next = mode_req;
      pend_next      = (mode_req != mode_next);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state     <= ST_CLEAR;
      prime_cnt <= '0;
      mode      <= MODE_BYPASS;
      pend      <= 1'b0;
      pend_mode <= MODE_BYPASS;
    end else begin
      state     <= state_next;
      prime_cnt <= prime_cnt_next;
      mode      <= mode_next;
      pend      <= pend_next;
      pend_mode <= pend_mode_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap             <= 2'd0;
      step_d1         <= 1'b0;
      wb_d2           <= 1'b0;
      mute_d1         <= 1'b0;
      mute_d2         <= 1'b0;
      sample_left     <= '0;
      sample_right    <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      overrun_cnt     <= '0;
    end else begin
      if (transfer) gap <= 2'd2;
      else if (gap != 2'd0) gap <= gap - 2'd1;

      step_d1 <= transfer;
      mute_d1 <= transfer && (state == ST_PRIME);
      wb_d2   <= step_d1;
      mute_d2 <= mute_d1;

      if (transfer) begin
        sample_left  <= readdata_left;
        sample_right <= readdata_right;
      end

      // Priming mute travels with the sample, since state may already be RUN at writeback.
      if (wb_d2) begin
        if (mute_d2) begin
          writedata_left  <= '0;
          writedata_right <= '0;
        end else begin
          case (mode)
            MODE_BYPASS: begin
              writedata_left  <= sample_left;
              writedata_right <= sample_right;
            end
            MODE_FILTER: begin
              writedata_left  <= filt_left;
              writedata_right <= filt_right;
            end
            default: begin
              writedata_left  <= '0;
              writedata_right <= '0;
            end
          endcase
        end
      end

      if (active && read_ready && (!write_ready || gap != 2'd0) && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
